// File: rtl/rv_ifu.sv
// ---------------------------------------------------------------------------
// rv_ifu -- instruction fetch unit
//
// Purpose:
//   Issues one instruction-memory fetch at a time. Fetched words go into a
//   2-entry {inst, pc} queue that feeds the decode stage. A redirect flushes
//   the queue and restarts fetching at the new target. If a fetch is still
//   in flight when the redirect arrives, its response is dropped when it
//   returns.
//
// Parameters:
//   WIDTH     data / address width
//   RESET_PC  first fetch address after reset
//
// Ports:
//   clk, rst           single clock, synchronous active-high reset
//   imem_req_*         fetch request channel (valid/ready/addr)
//   imem_rsp_*         fetch response (valid/data), no backpressure
//   redirect_*         branch/jump redirect strobe and target
//   inst_valid/ready   decode handshake; inst/inst_pc are the queue head
//   fetch_fault        sticky misaligned-redirect flag
//
// Build option:
//   IFU_MISALIGN_CHECK_EN  when defined, a redirect target with a non-zero
//                          low 2 bits sets fetch_fault, flushes the queue and
//                          stops all further fetching until reset. When it
//                          is not defined, the low 2 bits of the target are
//                          cleared and fetch_fault is tied low.
// ---------------------------------------------------------------------------
module rv_ifu #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h8000_0000)
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [WIDTH-1:0] imem_req_addr,
    input  logic             imem_rsp_valid,
    input  logic [WIDTH-1:0] imem_rsp_data,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [WIDTH-1:0] inst,
    output logic [WIDTH-1:0] inst_pc,
    output logic             fetch_fault
);

    localparam int DEPTH = 2;

    logic [WIDTH-1:0] r_fetch_pc;
    logic [WIDTH-1:0] r_req_pc;      // PC of the request currently in flight
    logic             r_out;         // one request outstanding
    logic             r_drop;        // outstanding response belongs to a flushed path
    logic [1:0]       r_count;
    logic             r_rd_ptr;
    logic             r_wr_ptr;
    logic [WIDTH-1:0] r_inst_mem [DEPTH];
    logic [WIDTH-1:0] r_pc_mem   [DEPTH];

    logic             w_halted;
    logic [WIDTH-1:0] w_redirect_target;
    logic             w_req_fire;
    logic             w_push;
    logic             w_pop;
    logic             w_not_empty;

    // -----------------------------------------------------------------------
    // Redirect target handling / misalignment fault
    // -----------------------------------------------------------------------
`ifdef IFU_MISALIGN_CHECK_EN
    logic r_halted;
    logic r_fault;

    assign w_redirect_target = redirect_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_halted <= 1'b0;
            r_fault  <= 1'b0;
        end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            r_halted <= 1'b1;
            r_fault  <= 1'b1;
        end
    end

    assign w_halted    = r_halted;
    assign fetch_fault = r_fault;
`else
    // Targets are always forced to word alignment.
    assign w_redirect_target = redirect_pc & ~WIDTH'(3);
    assign w_halted          = 1'b0;
    assign fetch_fault       = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Handshake qualifiers
    // -----------------------------------------------------------------------
    assign w_not_empty = (r_count != 2'd0);

    // A request is only issued when the queue is guaranteed room for its
    // response. Since out must be clear to issue, count alone bounds it.
    assign imem_req_valid = !rst && !r_out && !w_halted && !redirect_valid &&
                            (({1'b0, r_count} + {2'b00, r_out}) < 3'd2);
    assign imem_req_addr  = r_fetch_pc;

    assign w_req_fire = imem_req_valid && imem_req_ready;

    // Responses that arrive in a redirect cycle, or that belong to a
    // flushed path, never enter the queue.
    assign w_push = !rst && !redirect_valid && imem_rsp_valid && r_out && !r_drop;

    assign inst_valid = !rst && w_not_empty;
    assign w_pop      = inst_valid && inst_ready;

    // The head is read from registered storage, so a response reaches
    // inst_valid one cycle later and never combinationally.
    assign inst    = inst_valid ? r_inst_mem[r_rd_ptr] : '0;
    assign inst_pc = inst_valid ? r_pc_mem[r_rd_ptr]   : '0;

    // -----------------------------------------------------------------------
    // Queue storage (no reset needed; validity is tracked by r_count)
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (w_push && (r_wr_ptr == 1'(gi))) begin
                    r_inst_mem[gi] <= imem_rsp_data;
                    r_pc_mem[gi]   <= r_req_pc;
                end
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Control state
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= RESET_PC;
            r_out      <= 1'b0;
            r_drop     <= 1'b0;
            r_count    <= 2'd0;
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
        end else if (redirect_valid) begin
            // Flush; any pop in this cycle is absorbed by the flush.
            r_count    <= 2'd0;
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_fetch_pc <= w_redirect_target;
            if (r_out && !imem_rsp_valid) begin
                // Still waiting on the old path: remember to discard it.
                r_drop <= 1'b1;
            end else begin
                r_out  <= 1'b0;
                r_drop <= 1'b0;
            end
        end else begin
            // Issue and response are mutually exclusive (issue needs out=0).
            if (w_req_fire) begin
                r_out      <= 1'b1;
                r_req_pc   <= r_fetch_pc;
                r_fetch_pc <= r_fetch_pc + WIDTH'(4);
            end else if (r_out && imem_rsp_valid) begin
                r_out  <= 1'b0;
                r_drop <= 1'b0;
            end

            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

endmodule

// File: tb/tb_rv_ifu.sv
// ---------------------------------------------------------------------------
// tb_rv_ifu -- self-checking bench for rv_ifu
//
// A queue-based reference model tracks the fetch PC, the outstanding/drop
// flags and the instruction queue. A compare process checks every DUT
// output against it on each falling clock edge. Directed sequences with
// literal expectations come first, then a long stretch of random stimulus.
// ---------------------------------------------------------------------------
module tb_rv_ifu;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        fetch_fault;

    int total;
    int bad;

    rv_ifu #(.WIDTH(32), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .fetch_fault    (fetch_fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    ent_t        m_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_req_pc;
    bit          m_out;
    bit          m_drop;
    bit          m_fault;
    bit          m_halt;

    function automatic bit m_req_valid();
        return !rst && !m_out && !m_halt && !redirect_valid && (m_q.size() < 2);
    endfunction

    initial begin : model
        bit   fire;
        bit   pop;
        ent_t tmp;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_pc    = RESET_PC;
                m_q.delete();
                m_out   = 1'b0;
                m_drop  = 1'b0;
                m_fault = 1'b0;
                m_halt  = 1'b0;
            end else begin
                fire = m_req_valid() && imem_req_ready;
                pop  = (m_q.size() != 0) && inst_ready;
                if (redirect_valid) begin
`ifdef IFU_MISALIGN_CHECK_EN
                    if (redirect_pc[1:0] != 2'b00) begin
                        m_fault = 1'b1;
                        m_halt  = 1'b1;
                    end
                    m_pc = redirect_pc;
`else
                    m_pc = redirect_pc & 32'hFFFF_FFFC;
`endif
                    m_q.delete();
                    if (m_out) begin
                        if (imem_rsp_valid) begin
                            m_out  = 1'b0;
                            m_drop = 1'b0;
                        end else begin
                            m_drop = 1'b1;
                        end
                    end
                end else begin
                    if (pop) tmp = m_q.pop_front();
                    if (m_out && imem_rsp_valid) begin
                        if (!m_drop) m_q.push_back({imem_rsp_data, m_req_pc});
                        m_out  = 1'b0;
                        m_drop = 1'b0;
                    end
                    if (fire) begin
                        m_out    = 1'b1;
                        m_req_pc = m_pc;
                        m_pc     = m_pc + 32'd4;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Compare process: outputs vs model on every falling edge.
    initial begin : compare
        forever begin
            @(negedge clk);
            check("req_valid", {31'd0, imem_req_valid}, {31'd0, m_req_valid()});
            if (m_req_valid()) check("req_addr", imem_req_addr, m_pc);
            check("inst_valid", {31'd0, inst_valid}, {31'd0, (!rst && m_q.size() != 0)});
            if (rst) begin
                check("inst_in_reset", inst, 32'd0);
                check("inst_pc_in_reset", inst_pc, 32'd0);
            end else if (m_q.size() != 0) begin
                check("inst", inst, m_q[0].inst);
                check("inst_pc", inst_pc, m_q[0].pc);
            end
            check("fetch_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change 2 time units after the rising edge,
    // literal checks are taken 1 unit later.
    // ------------------------------------------------------------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
        check({"lit_", name}, got, exp);
    endtask

    logic [31:0] rnd;

    initial begin : stim
        total          = 0;
        bad            = 0;
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
        cyc();
        cyc();
        settle();
        lit("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        lit("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        lit("rst_inst", inst, 32'd0);

        // Reset release, first fetch and 1-cycle response.
        rst            = 1'b0;
        imem_req_ready = 1'b1;
        settle();
        lit("first_addr", imem_req_addr, 32'h8000_0000);
        cyc();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0013;
        cyc();
        imem_rsp_valid = 1'b0;
        settle();
        lit("first_inst", inst, 32'h0000_0013);
        lit("first_inst_pc", inst_pc, 32'h8000_0000);
        lit("second_addr", imem_req_addr, 32'h8000_0004);

        // Backpressure: queue fills, fetching stops, order preserved.
        cyc();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0010_0093;
        cyc();
        imem_rsp_valid = 1'b0;
        settle();
        lit("full_req_valid", {31'd0, imem_req_valid}, 32'd0);
        lit("full_head_pc", inst_pc, 32'h8000_0000);
        inst_ready = 1'b1;
        cyc();
        settle();
        lit("second_pc", inst_pc, 32'h8000_0004);
        lit("second_inst", inst, 32'h0010_0093);
        cyc();
        inst_ready = 1'b0;
        settle();
        lit("drained", {31'd0, inst_valid}, 32'd0);

        // Redirect while a fetch is outstanding; stale response dropped.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        settle();
        lit("redir_req_valid", {31'd0, imem_req_valid}, 32'd0);
        cyc();
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        cyc();
        imem_rsp_valid = 1'b0;
        settle();
        lit("stale_dropped", {31'd0, inst_valid}, 32'd0);
        lit("redir_addr", imem_req_addr, 32'h8000_0100);
        cyc();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0020_0113;
        cyc();
        imem_rsp_valid = 1'b0;
        settle();
        lit("redir_inst_pc", inst_pc, 32'h8000_0100);

        // Redirect coincident with a response and a pop.
        cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0200;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBADB_AD00;
        inst_ready     = 1'b1;
        settle();
        lit("coinc_pop_pc", inst_pc, 32'h8000_0100);
        cyc();
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        inst_ready     = 1'b0;
        settle();
        lit("coinc_empty", {31'd0, inst_valid}, 32'd0);
        lit("coinc_addr", imem_req_addr, 32'h8000_0200);

        // Memory stall: address held, request stays up.
        imem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            settle();
            lit("stall_valid", {31'd0, imem_req_valid}, 32'd1);
            lit("stall_addr", imem_req_addr, 32'h8000_0200);
        end
        imem_req_ready = 1'b1;
        cyc();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0013;
        cyc();
        imem_rsp_valid = 1'b0;

        // Misaligned redirect target.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0102;
        cyc();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        settle();
        lit("mis_flushed", {31'd0, inst_valid}, 32'd0);
`ifdef IFU_MISALIGN_CHECK_EN
        lit("mis_fault", {31'd0, fetch_fault}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            lit("mis_no_req", {31'd0, imem_req_valid}, 32'd0);
            cyc();
            settle();
        end
`else
        lit("mis_fault", {31'd0, fetch_fault}, 32'd0);
        lit("mis_addr", imem_req_addr, 32'h8000_0100);
`endif
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        cyc();
        cyc();
        settle();
        lit("fault_cleared", {31'd0, fetch_fault}, 32'd0);

        // Address wrap at the top of the address space.
        rst            = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        cyc();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        settle();
        lit("wrap_first", imem_req_addr, 32'hFFFF_FFFC);
        cyc();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0055;
        cyc();
        imem_rsp_valid = 1'b0;
        settle();
        lit("wrap_pc", inst_pc, 32'hFFFF_FFFC);
        lit("wrap_next", imem_req_addr, 32'h0000_0000);

        // Reset mid-request: a later response must be ignored.
        imem_req_ready = 1'b1;
        cyc();
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        cyc();
        rst            = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0077;
        cyc();
        imem_rsp_valid = 1'b0;
        settle();
        lit("abandoned_rsp", {31'd0, inst_valid}, 32'd0);
        lit("abandoned_addr", imem_req_addr, 32'h8000_0000);

        // Random stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
            rst            = ($urandom_range(0, 249) == 0);
            imem_req_ready = ($urandom_range(0, 3) != 0);
            imem_rsp_valid = ($urandom_range(0, 2) != 0);
            imem_rsp_data  = $urandom;
            redirect_valid = ($urandom_range(0, 15) == 0);
            rnd            = $urandom;
            if ($urandom_range(0, 9) == 0) redirect_pc = rnd;
            else                           redirect_pc = {rnd[31:2], 2'b00};
            inst_ready     = ($urandom_range(0, 1) != 0);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv_ifu.md
RV_IFU -- requirements
Module: rv_IFU

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the data and address width.
REQ-002 SHALL have parameter RESET_PC, default 32'h8000_0000, the first fetch address after reset.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, the reset; synchronous and active-high.
REQ-005 SHALL have port imem_req_valid, output, 1, fetch request valid.
REQ-006 SHALL have port imem_req_ready, input, 1, memory accepts the request.
REQ-007 SHALL have port imem_req_addr, output, WIDTH, fetch address.
REQ-008 SHALL have port imem_rsp_valid, input, 1, response data valid.
REQ-009 SHALL have port imem_rsp_data, input, WIDTH, fetched instruction word.
REQ-010 SHALL have port redirect_valid, input, 1, branch/jump redirect strobe.
REQ-011 SHALL have port redirect_pc, input, WIDTH, redirect target.
REQ-012 SHALL have port inst_valid, output, 1, instruction available to the decode stage.
REQ-013 SHALL have port inst_ready, input, 1, decode stage accepts the instruction.
REQ-014 SHALL have port inst, output, WIDTH, instruction at the queue head.
REQ-015 SHALL have port inst_pc, output, WIDTH, PC of the queue head.
REQ-016 SHALL have port fetch_fault, output, 1, sticky misaligned-redirect flag.

Function
REQ-017 SHALL hold a 2-entry FIFO of {inst, pc}; inst_valid = FIFO not empty; inst/inst_pc = head entry; pop when inst_valid && inst_ready.
REQ-018 SHALL allow at most one outstanding memory request (the out flag).
REQ-019 SHALL assert imem_req_valid iff !out && !halted && !redirect_valid && (count + out) < 2; imem_req_addr = fetch_pc.
REQ-020 SHALL perform a request handshake on imem_req_valid && imem_req_ready: set out, latch the request PC, fetch_pc <= fetch_pc + 4 (mod 2^WIDTH, wrap 32'hFFFF_FFFC -> 0).
REQ-021 SHALL keep imem_req_addr stable while imem_req_valid is high and imem_req_ready is low.
REQ-022 SHALL push {imem_rsp_data, latched PC} and clear out on imem_rsp_valid while out=1 and drop=0; a response with out=0 SHALL be ignored.
REQ-023 SHALL support push and pop in the same cycle when full or empty-plus-one; count stays constant.
REQ-024 SHALL on redirect_valid: flush the FIFO (count <= 0), fetch_pc <= redirect_pc, and set drop if out=1 and no response arrives that cycle; a response arriving in the redirect cycle SHALL be discarded.
REQ-025 SHALL on response while drop=1: discard data, clear out and drop.
REQ-026 SHALL complete an inst handshake occurring in the redirect cycle; the flushed entries SHALL not reappear.
REQ-027 SHALL give a best-case latency of 1 cycle from the response to inst_valid (registered FIFO output, no combinational path rsp->inst).

Reset
REQ-028 SHALL on rst=1: fetch_pc <= RESET_PC, count <= 0, out <= 0, drop <= 0, fetch_fault <= 0; outputs read imem_req_valid=0, inst_valid=0, inst=0, inst_pc=0 during the reset cycle.
REQ-029 SHALL give rst priority over redirect and all handshakes; a reset mid-request SHALL abandon the request, and a later response with out=0 SHALL be ignored.
REQ-030 SHALL issue the first request (addr RESET_PC) in the first cycle after rst deasserts.

Configuration
REQ-031 SHALL, with IFU_MISALIGN_CHECK_EN defined, treat redirect_pc[1:0] != 0 as a fault: set fetch_fault (sticky until rst), set halted, flush as for a redirect, and issue no further requests.
REQ-032 SHALL, without IFU_MISALIGN_CHECK_EN, force redirect_pc[1:0] to 2'b00 and tie fetch_fault to 0.

Verification
REQ-033 SHALL verify reset: rst released, imem_req_ready=1, 1-cycle response 32'h00000013 -> inst_valid with inst=32'h00000013, inst_pc=32'h8000_0000; next request addr 32'h8000_0004.
REQ-034 SHALL verify backpressure: inst_ready=0 -> after 2 responses, imem_req_valid=0, FIFO holds PCs 0x8000_0000 and 0x8000_0004 in order.
REQ-035 SHALL verify a redirect while out=1: redirect_pc=32'h8000_0100, then stale response -> dropped; next inst_pc=32'h8000_0100.
REQ-036 SHALL verify a redirect coincident with a response and pop: response discarded, FIFO empty next cycle, request addr = redirect_pc.
REQ-037 SHALL verify memory stall: imem_req_ready low 5 cycles -> imem_req_addr constant, out stays 0.
REQ-038 SHALL verify the macro: with IFU_MISALIGN_CHECK_EN, redirect_pc=32'h8000_0102 -> fetch_fault=1, no requests; without it, the next request addr = 32'h8000_0100.
